// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer (IF/RR/EX/MA/RW, plus HALT) that drives the datapath strobes.
// MA stalls on RAM or UART back-pressure and is forced onward after a bounded number of wait cycles.
module stage_sequencer #(
    parameter int WAIT_MAX = 255,
    parameter int RET_W    = 32
) (
    input  logic             sysclk,
    input  logic             nrst,
    input  logic             run_en,
    input  logic             is_store,
    input  logic             io_store,
    input  logic             reg_we_req,
    input  logic             is_halt,
    input  logic             mem_busy,
    input  logic             uart_busy,
    output logic [2:0]       stage,
    output logic             decoder_rst,
    output logic             alu_rst,
    output logic             ram_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             uart_we,
    output logic             halted,
    output logic             timeout_err,
    output logic [RET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_RR   = 3'd1,
        S_EX   = 3'd2,
        S_MA   = 3'd3,
        S_RW   = 3'd4,
        S_HALT = 3'd5
    } stage_t;

    stage_t     state_reg;
    logic [7:0] wait_reg;
    logic       halt_reg;
    logic       ma_stall;
    logic       ma_timeout;

    assign ma_stall   = mem_busy || (is_store && io_store && uart_busy);
    assign ma_timeout = ma_stall && (wait_reg == 8'(WAIT_MAX));
    assign stage      = state_reg;

    // Every strobe is set on the edge that enters the stage it belongs to, so outputs stay registered.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= S_IF;
            wait_reg    <= 8'd0;
            halt_reg    <= 1'b0;
            decoder_rst <= 1'b0;
            alu_rst     <= 1'b0;
            ram_we      <= 1'b0;
            reg_we      <= 1'b0;
            pc_we       <= 1'b0;
            uart_we     <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            instret     <= '0;
        end else begin
            decoder_rst <= 1'b0;
            alu_rst     <= 1'b0;
            ram_we      <= 1'b0;
            reg_we      <= 1'b0;
            pc_we       <= 1'b0;
            uart_we     <= 1'b0;
            case (state_reg)
                S_IF: begin
                    if (run_en) begin
                        state_reg   <= S_RR;
                        decoder_rst <= 1'b1;
                    end
                end
                S_RR: begin
                    state_reg <= S_EX;
                    alu_rst   <= 1'b1;
                end
                S_EX: begin
                    state_reg <= S_MA;
                    wait_reg  <= 8'd0;
                    ram_we    <= is_store && !io_store;
                end
                S_MA: begin
                    if (ma_stall && !ma_timeout) begin
                        if (wait_reg != 8'hFF) begin
                            wait_reg <= wait_reg + 8'd1;
                        end
                    end else begin
                        // Halt decision is captured here so pc_we and the RW exit always agree.
                        state_reg <= S_RW;
                        uart_we   <= is_store && io_store;
                        reg_we    <= reg_we_req;
                        pc_we     <= !is_halt;
                        halt_reg  <= is_halt;
                        if (ma_timeout) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_RW: begin
                    instret <= instret + RET_W'(1);
                    if (halt_reg) begin
                        state_reg <= S_HALT;
                        halted    <= 1'b1;
                    end else begin
                        state_reg <= S_IF;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction stage/strobe sequences derived from stall lengths,
// with a second narrow-counter instance to observe instret wrap.
module tb_stage_sequencer;

    localparam int WAIT_MAX = 255;

    logic        sysclk = 1'b0;
    logic        nrst, run_en, is_store, io_store, reg_we_req, is_halt, mem_busy, uart_busy;
    logic [2:0]  stage, stage_w;
    logic        decoder_rst, alu_rst, ram_we, reg_we, pc_we, uart_we, halted, timeout_err;
    logic        decoder_rst_w, alu_rst_w, ram_we_w, reg_we_w, pc_we_w, uart_we_w, halted_w, timeout_err_w;
    logic [31:0] instret;
    logic [3:0]  instret_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret = '0;
    bit          exp_timeout = 1'b0;

    logic [10:0] ctl_out;
    assign ctl_out = {stage, decoder_rst, alu_rst, ram_we, reg_we, pc_we, uart_we, halted, timeout_err};

    typedef struct {
        logic [2:0] st;
        logic [5:0] strb;
        int         k;
        bit         run;
    } step_t;

    always #5 sysclk = ~sysclk;

    stage_sequencer #(.WAIT_MAX(WAIT_MAX), .RET_W(32)) dut (
        .sysclk(sysclk), .nrst(nrst), .run_en(run_en), .is_store(is_store), .io_store(io_store),
        .reg_we_req(reg_we_req), .is_halt(is_halt), .mem_busy(mem_busy), .uart_busy(uart_busy),
        .stage(stage), .decoder_rst(decoder_rst), .alu_rst(alu_rst), .ram_we(ram_we),
        .reg_we(reg_we), .pc_we(pc_we), .uart_we(uart_we), .halted(halted),
        .timeout_err(timeout_err), .instret(instret)
    );

    stage_sequencer #(.WAIT_MAX(WAIT_MAX), .RET_W(4)) dut_w (
        .sysclk(sysclk), .nrst(nrst), .run_en(run_en), .is_store(is_store), .io_store(io_store),
        .reg_we_req(reg_we_req), .is_halt(is_halt), .mem_busy(mem_busy), .uart_busy(uart_busy),
        .stage(stage_w), .decoder_rst(decoder_rst_w), .alu_rst(alu_rst_w), .ram_we(ram_we_w),
        .reg_we(reg_we_w), .pc_we(pc_we_w), .uart_we(uart_we_w), .halted(halted_w),
        .timeout_err(timeout_err_w), .instret(instret_w)
    );

    task automatic randomize_inputs();
        is_store   = 1'($urandom);
        io_store   = 1'($urandom);
        reg_we_req = 1'($urandom);
        is_halt    = 1'($urandom);
        mem_busy   = 1'($urandom);
        uart_busy  = 1'($urandom);
    endtask

    task automatic do_reset();
        nrst   = 1'b0;
        run_en = 1'b0;
        randomize_inputs();
        @(negedge sysclk);
        nrst        = 1'b1;
        exp_instret = '0;
        exp_timeout = 1'b0;
    endtask

    // Builds the expected stage/strobe trace of one instruction from its stall length, then
    // steps the DUT through it. Inputs are held only in the stages that consume them.
    task automatic run_instr(input bit s, input bit io, input bit rwe, input bit hlt,
                             input int m, input int u, input int idle, input bit abort_rw);
        step_t q[$];
        step_t e;
        int    stall;
        int    len;
        bit    to;
        stall = (s && io && u > m) ? u : m;
        to    = (stall > WAIT_MAX);
        len   = (to ? WAIT_MAX : stall) + 1;
        for (int i = 0; i < idle; i++) q.push_back('{3'd0, 6'b000000, 0, 1'b0});
        q.push_back('{3'd0, 6'b000000, 0, 1'b1});
        q.push_back('{3'd1, 6'b100000, 0, 1'b0});
        q.push_back('{3'd2, 6'b010000, 0, 1'b0});
        for (int k = 1; k <= len; k++)
            q.push_back('{3'd3, {2'b00, ((k == 1) && s && !io), 3'b000}, k, 1'b0});
        q.push_back('{3'd4, {3'b000, rwe, !hlt, (s && io)}, 0, 1'b0});
        if (hlt) for (int i = 0; i < 4; i++) q.push_back('{3'd5, 6'b000000, 0, 1'b0});

        foreach (q[i]) begin
            e = q[i];
            if (e.st == 3'd4 && to) exp_timeout = 1'b1;
            n_checks++;
            if (ctl_out !== {e.st, e.strb, (e.st == 3'd5), exp_timeout}) begin
                n_fail++;
                $display("FAIL seq_ctl step=%0d ma_k=%0d got stage/strobes/halted/to=%b expected %b",
                         i, e.k, ctl_out, {e.st, e.strb, (e.st == 3'd5), exp_timeout});
            end
            n_checks++;
            if (instret !== exp_instret || instret_w !== exp_instret[3:0]) begin
                n_fail++;
                $display("FAIL seq_instret step=%0d got %0d/%0d expected %0d/%0d",
                         i, instret, instret_w, exp_instret, exp_instret[3:0]);
            end
            if (e.st == 3'd4 && abort_rw) begin
                nrst = 1'b0;
                #1;
                exp_instret = '0;
                exp_timeout = 1'b0;
                n_checks++;
                if ({ctl_out, instret, instret_w} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_rw_reset got %b instret=%0d expected all zero", ctl_out, instret);
                end
                run_en = 1'b0;
                @(negedge sysclk);
                nrst = 1'b1;
                return;
            end
            if (e.st == 3'd4) exp_instret++;
            run_en = (e.st == 3'd0) ? e.run : 1'($urandom);
            if (e.st == 3'd2 || e.st == 3'd3 || e.st == 3'd4) begin
                is_store = s; io_store = io; reg_we_req = rwe; is_halt = hlt;
            end else begin
                is_store = 1'($urandom); io_store = 1'($urandom);
                reg_we_req = 1'($urandom); is_halt = 1'($urandom);
            end
            mem_busy  = (e.st == 3'd3) ? (e.k <= m) : 1'($urandom);
            uart_busy = (e.st == 3'd3) ? (e.k <= u) : 1'($urandom);
            @(negedge sysclk);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; run_en = 1'b1; is_store = 1'b1; io_store = 1'b0;
        reg_we_req = 1'b1; is_halt = 1'b0; mem_busy = 1'b0; uart_busy = 1'b0;
        #1;
        n_checks++;
        if ({ctl_out, instret, instret_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %b instret=%0d expected all zero", ctl_out, instret);
        end
        @(negedge sysclk);
        n_checks++;
        if (ctl_out !== '0) begin
            n_fail++;
            $display("FAIL reset_held got %b expected 0", ctl_out);
        end
        run_en = 1'b0;
        nrst   = 1'b1;
        repeat (3) begin
            @(negedge sysclk);
            n_checks++;
            if (stage !== 3'd0) begin
                n_fail++;
                $display("FAIL idle_if got stage=%0d expected 0", stage);
            end
        end
        run_en = 1'b1;
        @(negedge sysclk);
        n_checks++;
        if (stage !== 3'd1 || decoder_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL first_rr got stage=%0d decoder_rst=%b expected 1/1", stage, decoder_rst);
        end
        do_reset();
    endtask

    task automatic test_alu_op();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b0);
        n_checks++;
        if (instret !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_instret got %0d expected 1", instret);
        end
    endtask

    task automatic test_store_stall();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 0, 1'b0);
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1, 4, 1, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 255, 0, 0, 1'b0);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge255 got %b expected 0", timeout_err);
        end
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 0, 300, 0, 1'b0);
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_uart got %b expected 1", timeout_err);
        end
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        do_reset();
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 256, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 20; n++)
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic test_uart_abort();
        do_reset();
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 0, 2, 0, 1'b1);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_ma();
        do_reset();
        run_en = 1'b1; is_store = 1'b1; io_store = 1'b1; uart_busy = 1'b1; mem_busy = 1'b1;
        repeat (3) @(negedge sysclk);
        repeat (5) begin
            n_checks++;
            if (stage !== 3'd3 || ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL ma_stall got stage=%0d ram_we=%b expected 3/0", stage, ram_we);
            end
            @(negedge sysclk);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({ctl_out, instret} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_ma got %b expected all zero", ctl_out);
        end
        run_en = 1'b0;
        @(negedge sysclk);
        nrst = 1'b1;
        exp_instret = '0;
        exp_timeout = 1'b0;
        repeat (4) begin
            @(negedge sysclk);
            n_checks++;
            if (stage !== 3'd0) begin
                n_fail++;
                $display("FAIL hold_if got stage=%0d expected 0", stage);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        repeat (6) begin
            run_en = 1'b1;
            randomize_inputs();
            @(negedge sysclk);
            n_checks++;
            if (stage !== 3'd5 || halted !== 1'b1 || pc_we !== 1'b0 || instret !== 32'd1) begin
                n_fail++;
                $display("FAIL halt_hold got stage=%0d halted=%b pc_we=%b instret=%0d expected 5/1/0/1",
                         stage, halted, pc_we, instret);
            end
        end
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 16; n++)
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 1'b0);
        n_checks++;
        if (instret_w !== 4'd0 || instret !== 32'd16) begin
            n_fail++;
            $display("FAIL instret_wrap got %0d/%0d expected 0/16", instret_w, instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_store_stall();
        test_timeout();
        test_random();
        test_uart_abort();
        test_reset_mid_ma();
        test_halt();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
